// File: rtl/poly_loader_pkg.sv
// Shared constants and types for the polygon parameter loader: opcodes,
// payload field map and the command-parser state encoding.
package poly_loader_pkg;

   localparam logic [1:0] OP_NOP    = 2'b00;
   localparam logic [1:0] OP_POLY   = 2'b01;
   localparam logic [1:0] OP_BG     = 2'b10;
   localparam logic [1:0] OP_COMMIT = 2'b11;

   localparam int unsigned POLY_PAY_BYTES = 7;
   localparam int unsigned PAY_W          = 8 * POLY_PAY_BYTES;
   localparam int unsigned SLOT_W         = 49;

   localparam int unsigned X_W     = 7;
   localparam int unsigned Y_W     = 6;
   localparam int unsigned COL_W   = 6;
   localparam int unsigned DEP_W   = 3;
   localparam int unsigned V0X_LSB = 0;
   localparam int unsigned V0Y_LSB = 7;
   localparam int unsigned V1X_LSB = 13;
   localparam int unsigned V1Y_LSB = 20;
   localparam int unsigned V2X_LSB = 26;
   localparam int unsigned V2Y_LSB = 33;
   localparam int unsigned COL_LSB = 39;
   localparam int unsigned DEP_LSB = 45;
   localparam int unsigned EN_BIT  = 48;

   typedef enum logic [1:0] {
      StIdle,
      StPolyPay,
      StBgPay,
      StWaitSwap
   } state_e;

endpackage

// File: rtl/poly_slot_regs.sv
// One polygon slot: shadow word written by the host parser, active word
// loaded from shadow on the frame-boundary swap strobe.
module poly_slot_regs
   import poly_loader_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_wr_en,
   input  logic [SLOT_W-1:0] i_wr_word,
   input  logic              i_swap,
   output logic [X_W-1:0]    o_v0_x,
   output logic [Y_W-1:0]    o_v0_y,
   output logic [X_W-1:0]    o_v1_x,
   output logic [Y_W-1:0]    o_v1_y,
   output logic [X_W-1:0]    o_v2_x,
   output logic [Y_W-1:0]    o_v2_y,
   output logic [COL_W-1:0]  o_color,
   output logic [DEP_W-1:0]  o_depth,
   output logic              o_en
);

   logic [SLOT_W-1:0] r_shadow;
   logic [SLOT_W-1:0] r_active;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_shadow <= '0;
         r_active <= '0;
      end else begin
         if (i_wr_en) r_shadow <= i_wr_word;
         if (i_swap)  r_active <= r_shadow;
      end
   end

   assign o_v0_x  = r_active[V0X_LSB +: X_W];
   assign o_v0_y  = r_active[V0Y_LSB +: Y_W];
   assign o_v1_x  = r_active[V1X_LSB +: X_W];
   assign o_v1_y  = r_active[V1Y_LSB +: Y_W];
   assign o_v2_x  = r_active[V2X_LSB +: X_W];
   assign o_v2_y  = r_active[V2Y_LSB +: Y_W];
   assign o_color = r_active[COL_LSB +: COL_W];
   assign o_depth = r_active[DEP_LSB +: DEP_W];
   assign o_en    = r_active[EN_BIT];

endmodule

// File: rtl/poly_param_loader.sv
// Byte-serial command decoder feeding double-buffered polygon and background
// registers; shadow is copied to active only on a frame_start after COMMIT.
module poly_param_loader
   import poly_loader_pkg::*;
#(
   parameter int unsigned NUM_POLY = 2,
   parameter int unsigned IDX_W    = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [7:0]            in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  frame_start,
   output logic                  swap_pulse,
   output logic [7*NUM_POLY-1:0] v0_x,
   output logic [7*NUM_POLY-1:0] v1_x,
   output logic [7*NUM_POLY-1:0] v2_x,
   output logic [6*NUM_POLY-1:0] v0_y,
   output logic [6*NUM_POLY-1:0] v1_y,
   output logic [6*NUM_POLY-1:0] v2_y,
   output logic [6*NUM_POLY-1:0] poly_color,
   output logic [3*NUM_POLY-1:0] poly_depth,
   output logic [NUM_POLY-1:0]   cmp_en,
   output logic [5:0]            background_color
);

   localparam int unsigned ASM_W = 8 * (POLY_PAY_BYTES - 1);

   state_e           r_state;
   logic [2:0]       r_cnt;
   logic [IDX_W-1:0] r_idx;
   logic [ASM_W-1:0] r_asm;
   logic [5:0]       r_bg_shadow;
   logic [5:0]       r_bg_active;
   logic             r_swap_pulse;

   logic              w_fire;
   logic              w_last;
   logic              w_swap;
   logic [1:0]        w_op;
   logic [SLOT_W-1:0] w_slot_word;

   assign in_ready    = !rst && (r_state != StWaitSwap);
   assign w_fire      = in_valid && in_ready;
   assign w_op        = in_data[7:6];
   assign w_last      = (r_state == StPolyPay) && w_fire && (r_cnt == 3'(POLY_PAY_BYTES - 1));
   assign w_swap      = (r_state == StWaitSwap) && frame_start;
   // Final byte completes the word combinationally so the slot write lands on the same edge.
   assign w_slot_word = {in_data[SLOT_W-ASM_W-1:0], r_asm};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= StIdle;
         r_cnt        <= '0;
         r_idx        <= '0;
         r_asm        <= '0;
         r_bg_shadow  <= '0;
         r_bg_active  <= '0;
         r_swap_pulse <= 1'b0;
      end else begin
         r_swap_pulse <= w_swap;
         if (w_swap) r_bg_active <= r_bg_shadow;
         unique case (r_state)
            StIdle: begin
               if (w_fire) begin
                  r_idx <= in_data[IDX_W-1:0];
                  case (w_op)
                     OP_POLY: begin
                        r_state <= StPolyPay;
                        r_cnt   <= '0;
                     end
                     OP_BG:     r_state <= StBgPay;
                     OP_COMMIT: r_state <= StWaitSwap;
                     default:   r_state <= StIdle;
                  endcase
               end
            end
            StPolyPay: begin
               if (w_fire) begin
                  // Shift in at the top so byte0 ends up in bits [7:0] after six bytes.
                  r_asm <= {in_data, r_asm[ASM_W-1:8]};
                  r_cnt <= r_cnt + 3'd1;
                  if (w_last) r_state <= StIdle;
               end
            end
            StBgPay: begin
               if (w_fire) begin
                  r_bg_shadow <= in_data[5:0];
                  r_state     <= StIdle;
               end
            end
            StWaitSwap: begin
               if (w_swap) r_state <= StIdle;
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign swap_pulse       = r_swap_pulse;
   assign background_color = r_bg_active;

   for (genvar g = 0; g < NUM_POLY; g++) begin : g_slot
      logic w_wr_en;
      // Out-of-range indices match no slot, so their payload is consumed and dropped.
      assign w_wr_en = w_last && (r_idx == IDX_W'(g));

      poly_slot_regs u_slot (
         .i_clk     (clk),
         .i_rst     (rst),
         .i_wr_en   (w_wr_en),
         .i_wr_word (w_slot_word),
         .i_swap    (w_swap),
         .o_v0_x    (v0_x[g*X_W +: X_W]),
         .o_v0_y    (v0_y[g*Y_W +: Y_W]),
         .o_v1_x    (v1_x[g*X_W +: X_W]),
         .o_v1_y    (v1_y[g*Y_W +: Y_W]),
         .o_v2_x    (v2_x[g*X_W +: X_W]),
         .o_v2_y    (v2_y[g*Y_W +: Y_W]),
         .o_color   (poly_color[g*COL_W +: COL_W]),
         .o_depth   (poly_depth[g*DEP_W +: DEP_W]),
         .o_en      (cmp_en[g])
      );
   end

endmodule

// File: tb/tb_poly_param_loader.sv
// Randomized bench for poly_param_loader: a command-level model predicts each
// swap's active snapshot, and a monitor compares it whenever swap_pulse fires.
module tb_poly_param_loader;

   localparam int NP     = 2;
   localparam int SW     = 49;
   localparam int SNAP_W = NP * SW + 6;

   logic              clk = 1'b0;
   logic              rst;
   logic [7:0]        in_data;
   logic              in_valid;
   logic              in_ready;
   logic              frame_start;
   logic              swap_pulse;
   logic [7*NP-1:0]   v0_x, v1_x, v2_x;
   logic [6*NP-1:0]   v0_y, v1_y, v2_y;
   logic [6*NP-1:0]   poly_color;
   logic [3*NP-1:0]   poly_depth;
   logic [NP-1:0]     cmp_en;
   logic [5:0]        background_color;

   always #5 clk = ~clk;

   poly_param_loader #(.NUM_POLY(NP), .IDX_W(3)) dut (
      .clk              (clk),
      .rst              (rst),
      .in_data          (in_data),
      .in_valid         (in_valid),
      .in_ready         (in_ready),
      .frame_start      (frame_start),
      .swap_pulse       (swap_pulse),
      .v0_x             (v0_x),
      .v1_x             (v1_x),
      .v2_x             (v2_x),
      .v0_y             (v0_y),
      .v1_y             (v1_y),
      .v2_y             (v2_y),
      .poly_color       (poly_color),
      .poly_depth       (poly_depth),
      .cmp_en           (cmp_en),
      .background_color (background_color)
   );

   int n_tests    = 0;
   int n_fail     = 0;
   int swaps_exp  = 0;
   int swaps_seen = 0;

   logic [SNAP_W-1:0] exp_q[$];
   logic [SW-1:0]     m_sh[NP];
   logic [SW-1:0]     m_act[NP];
   logic [5:0]        m_bg_sh, m_bg_act;
   bit                m_pending;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [SNAP_W-1:0] snap_active();
      logic [SNAP_W-1:0] s;
      for (int i = 0; i < NP; i++) s[i*SW +: SW] = m_act[i];
      s[NP*SW +: 6] = m_bg_act;
      return s;
   endfunction

   // Payload per the documented little-endian field map; top 7 bits are don't-care.
   function automatic logic [55:0] make_pay(input logic [6:0] x0, input logic [5:0] y0,
                                            input logic [6:0] x1, input logic [5:0] y1,
                                            input logic [6:0] x2, input logic [5:0] y2,
                                            input logic [5:0] col, input logic [2:0] dep,
                                            input logic en);
      logic [6:0] junk;
      junk = 7'($urandom);
      return {junk, en, dep, col, y2, x2, y1, x1, y0, x0};
   endfunction

   task automatic check_outputs(input string tag, input logic [SNAP_W-1:0] s);
      logic [7*NP-1:0] e0x, e1x, e2x;
      logic [6*NP-1:0] e0y, e1y, e2y, ec;
      logic [3*NP-1:0] ed;
      logic [NP-1:0]   ee;
      logic [SW-1:0]   w;
      for (int i = 0; i < NP; i++) begin
         w = s[i*SW +: SW];
         e0x[i*7 +: 7] = w[6:0];
         e0y[i*6 +: 6] = w[12:7];
         e1x[i*7 +: 7] = w[19:13];
         e1y[i*6 +: 6] = w[25:20];
         e2x[i*7 +: 7] = w[32:26];
         e2y[i*6 +: 6] = w[38:33];
         ec[i*6 +: 6]  = w[44:39];
         ed[i*3 +: 3]  = w[47:45];
         ee[i]         = w[48];
      end
      check({tag, ".v0_x"}, 64'(v0_x), 64'(e0x));
      check({tag, ".v0_y"}, 64'(v0_y), 64'(e0y));
      check({tag, ".v1_x"}, 64'(v1_x), 64'(e1x));
      check({tag, ".v1_y"}, 64'(v1_y), 64'(e1y));
      check({tag, ".v2_x"}, 64'(v2_x), 64'(e2x));
      check({tag, ".v2_y"}, 64'(v2_y), 64'(e2y));
      check({tag, ".color"}, 64'(poly_color), 64'(ec));
      check({tag, ".depth"}, 64'(poly_depth), 64'(ed));
      check({tag, ".cmp_en"}, 64'(cmp_en), 64'(ee));
      check({tag, ".bg"}, 64'(background_color), 64'(s[NP*SW +: 6]));
   endtask

   // Monitor: every swap_pulse must match the oldest predicted snapshot.
   initial begin
      forever begin
         @(negedge clk);
         if (rst === 1'b0 && swap_pulse === 1'b1) begin
            swaps_seen++;
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_swap: got swap_pulse=1, expected no swap");
            end else begin
               check_outputs("swap", exp_q.pop_front());
            end
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      @(negedge clk);
      in_data  = b;
      in_valid = 1'b1;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) check("send_ready_timeout", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic send_poly(input int idx, input logic [55:0] pay, input bit gaps);
      logic [2:0] ix;
      ix = idx[2:0];
      send_byte({2'b01, 3'($urandom), ix});
      for (int k = 0; k < 7; k++) begin
         if (gaps) idle(1);
         send_byte(pay[k*8 +: 8]);
      end
      if (idx < NP) m_sh[idx] = pay[SW-1:0];
   endtask

   task automatic send_bg(input logic [5:0] c);
      send_byte({2'b10, 6'($urandom)});
      send_byte({2'($urandom), c});
      m_bg_sh = c;
   endtask

   task automatic send_nop();
      send_byte({2'b00, 6'($urandom)});
   endtask

   task automatic send_commit();
      send_byte({2'b11, 6'($urandom)});
      m_pending = 1'b1;
   endtask

   task automatic pulse_frame();
      @(negedge clk);
      frame_start = 1'b1;
      @(posedge clk);
      #1 frame_start = 1'b0;
      if (m_pending) begin
         for (int i = 0; i < NP; i++) m_act[i] = m_sh[i];
         m_bg_act  = m_bg_sh;
         m_pending = 1'b0;
         exp_q.push_back(snap_active());
         swaps_exp++;
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 6 && exp_q.size() != 0; i++) begin
         @(negedge clk);
         #1;
      end
      if (exp_q.size() != 0) begin
         check("swap_timeout", 64'(exp_q.size()), 64'd0);
         exp_q.delete();
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst         = 1'b1;
      in_valid    = 1'b0;
      frame_start = 1'b0;
      #1 check("ready_in_reset", 64'(in_ready), 64'd0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < NP; i++) begin
         m_sh[i]  = '0;
         m_act[i] = '0;
      end
      m_bg_sh   = '0;
      m_bg_act  = '0;
      m_pending = 1'b0;
      exp_q.delete();
   endtask

   initial begin
      logic [55:0] pay;
      int          r;
      rst         = 1'b1;
      in_valid    = 1'b0;
      in_data     = '0;
      frame_start = 1'b0;
      do_reset();

      // Reset and idle.
      idle(10);
      #1;
      check_outputs("reset", snap_active());
      check("reset.in_ready", 64'(in_ready), 64'd1);
      check("reset.swap_pulse", 64'(swap_pulse), 64'd0);

      // Slot 1 polygon, commit, swap.
      pay = make_pay(7'd10, 6'd5, 7'd100, 6'd5, 7'd50, 6'd40, 6'h30, 3'd2, 1'b1);
      send_poly(1, pay, 1'b0);
      send_commit();
      idle(3);
      #1;
      check("wait.in_ready", 64'(in_ready), 64'd0);
      check_outputs("pre_swap", snap_active());
      pulse_frame();
      drain();
      idle(3);
      #1;
      check("t2.v0_x1", 64'(v0_x[13:7]), 64'd10);
      check("t2.v1_x1", 64'(v1_x[13:7]), 64'd100);
      check("t2.color1", 64'(poly_color[11:6]), 64'h30);
      check("t2.cmp_en", 64'(cmp_en), 64'b10);
      check("t2.swap_count", 64'(swaps_seen), 64'd1);
      check("t2.in_ready", 64'(in_ready), 64'd1);

      // COMMIT coincident with frame_start must wait for the next pulse.
      send_bg(6'h0C);
      @(negedge clk);
      in_data     = {2'b11, 6'h00};
      in_valid    = 1'b1;
      frame_start = 1'b1;
      check("t3.commit_ready", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      in_valid    = 1'b0;
      frame_start = 1'b0;
      m_pending   = 1'b1;
      idle(3);
      #1;
      check("t3.no_early_swap", 64'(swaps_seen), 64'(swaps_exp));
      check("t3.bg_held", 64'(background_color), 64'd0);
      pulse_frame();
      drain();
      check("t3.bg", 64'(background_color), 64'h0C);

      // NOPs, then slot 0 with gapped payload bytes.
      send_nop();
      idle(1);
      send_nop();
      pay = make_pay(7'($urandom), 6'($urandom), 7'($urandom), 6'($urandom), 7'($urandom),
                     6'($urandom), 6'($urandom), 3'($urandom), 1'b1);
      send_poly(0, pay, 1'b1);
      send_commit();
      pulse_frame();
      drain();

      // Reset in the middle of a slot-0 packet.
      send_byte({2'b01, 6'd0});
      for (int k = 0; k < 4; k++) send_byte(8'($urandom));
      do_reset();
      send_commit();
      pulse_frame();
      drain();
      check("t5.cmp_en", 64'(cmp_en), 64'd0);

      // Out-of-range slot payload must be fully consumed.
      pay = make_pay(7'($urandom), 6'($urandom), 7'($urandom), 6'($urandom), 7'($urandom),
                     6'($urandom), 6'($urandom), 3'($urandom), 1'b1);
      send_poly(5, pay, 1'b0);
      send_bg(6'h3F);
      send_commit();
      pulse_frame();
      drain();
      check("t6.bg", 64'(background_color), 64'h3F);

      // Random command mix, including stray frame_start pulses.
      for (int it = 0; it < 60; it++) begin
         r = $urandom_range(0, 4);
         case (r)
            0: begin
               pay = make_pay(7'($urandom), 6'($urandom), 7'($urandom), 6'($urandom),
                              7'($urandom), 6'($urandom), 6'($urandom), 3'($urandom),
                              1'($urandom));
               send_poly($urandom_range(0, 7), pay, 1'($urandom));
            end
            1: send_bg(6'($urandom));
            2: send_nop();
            3: begin
               send_commit();
               idle($urandom_range(0, 3));
               pulse_frame();
               drain();
            end
            default: pulse_frame();
         endcase
      end
      send_commit();
      pulse_frame();
      drain();

      idle(5);
      check("final.swap_count", 64'(swaps_seen), 64'(swaps_exp));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
